// File: rtl/i2s_top.sv
// I2S transmitter and receiver joined in internal loopback, sharing one bit-clock divider.
// The serial bus is exposed on outputs purely for observation.

module i2s_clkgen #(
    parameter int unsigned DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [DW-1:0] prescaler_i,
    output logic          bclk_o,
    output logic          rise_o,
    output logic          fall_o
);

    logic [DW-1:0] cnt_q, cnt_d;
    logic          bclk_q, bclk_d;
    logic          wrap;

    // The prescaler is compared live, so a new value applies at the next comparison.
    always_comb begin
        wrap   = (cnt_q >= prescaler_i);
        cnt_d  = wrap ? '0 : cnt_q + DW'(1);
        bclk_d = bclk_q ^ wrap;
        rise_o = wrap & ~bclk_q;
        fall_o = wrap & bclk_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk_o = bclk_q;

endmodule

module i2s_tx #(
    parameter int unsigned DW = 16,
    parameter int unsigned NW = $clog2(2 * DW)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          fall_i,
    input  logic [DW-1:0] left_i,
    input  logic [DW-1:0] right_i,
    output logic          ws_o,
    output logic          sd_o,
    output logic [NW-1:0] bit_idx_o
);

    localparam int unsigned FW = 2 * DW;

    logic [NW-1:0] n_q, n_d;
    logic          ws_q, ws_d;
    logic [FW-1:0] sr_q, sr_d;

    // Loading at n=1 rather than n=0 gives the Philips one-bit lag of SD behind WS;
    // the right LSB then shifts out during n=0 of the following frame.
    always_comb begin
        n_d  = n_q;
        ws_d = ws_q;
        sr_d = sr_q;
        if (fall_i) begin
            n_d  = (n_q == NW'(FW - 1)) ? '0 : n_q + NW'(1);
            ws_d = (n_d >= NW'(DW));
            if (n_d == NW'(1)) begin
                sr_d = {left_i, right_i};
            end else begin
                sr_d = {sr_q[FW-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n_q  <= NW'(FW - 1);
            ws_q <= 1'b1;
            sr_q <= '0;
        end else begin
            n_q  <= n_d;
            ws_q <= ws_d;
            sr_q <= sr_d;
        end
    end

    assign ws_o      = ws_q;
    assign sd_o      = sr_q[FW-1];
    assign bit_idx_o = n_q;

endmodule

module i2s_rx #(
    parameter int unsigned DW = 16,
    parameter int unsigned NW = $clog2(2 * DW)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          rise_i,
    input  logic          sd_i,
    input  logic [NW-1:0] bit_idx_i,
    output logic [DW-1:0] left_o,
    output logic [DW-1:0] right_o
);

    logic [DW-1:0] sr_q, sr_d;
    logic [DW-1:0] left_q, left_d;
    logic [DW-1:0] right_q, right_d;
    logic [DW-1:0] word;

    // The word includes the bit sampled on this very rise, so it is built combinationally.
    always_comb begin
        word    = {sr_q[DW-2:0], sd_i};
        sr_d    = sr_q;
        left_d  = left_q;
        right_d = right_q;
        if (rise_i) begin
            sr_d = word;
            if (bit_idx_i == NW'(DW)) begin
                left_d = word;
            end
            if (bit_idx_i == '0) begin
                right_d = word;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q    <= '0;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            sr_q    <= sr_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign left_o  = left_q;
    assign right_o = right_q;

endmodule

module i2s_top #(
    parameter int unsigned AUDIO_DW = 16
) (
    input  logic                i_tx_sclk,
    input  logic                i_rst_n,
    input  logic [AUDIO_DW-1:0] i_tx_prescaler,
    input  logic [AUDIO_DW-1:0] i_tx_left_chan,
    input  logic [AUDIO_DW-1:0] i_tx_right_chan,
    output logic [AUDIO_DW-1:0] o_rx_left_chan,
    output logic [AUDIO_DW-1:0] o_rx_right_chan,
    output logic                o_i2s_bclk,
    output logic                o_i2s_ws,
    output logic                o_i2s_sd
);

    localparam int unsigned NW = $clog2(2 * AUDIO_DW);

    logic          bclk;
    logic          rise;
    logic          fall;
    logic          ws;
    logic          sd;
    logic [NW-1:0] bit_idx;

    i2s_clkgen #(.DW(AUDIO_DW)) u_clkgen (
        .clk_i       (i_tx_sclk),
        .rst_ni      (i_rst_n),
        .prescaler_i (i_tx_prescaler),
        .bclk_o      (bclk),
        .rise_o      (rise),
        .fall_o      (fall)
    );

    i2s_tx #(.DW(AUDIO_DW), .NW(NW)) u_tx (
        .clk_i     (i_tx_sclk),
        .rst_ni    (i_rst_n),
        .fall_i    (fall),
        .left_i    (i_tx_left_chan),
        .right_i   (i_tx_right_chan),
        .ws_o      (ws),
        .sd_o      (sd),
        .bit_idx_o (bit_idx)
    );

    i2s_rx #(.DW(AUDIO_DW), .NW(NW)) u_rx (
        .clk_i     (i_tx_sclk),
        .rst_ni    (i_rst_n),
        .rise_i    (rise),
        .sd_i      (sd),
        .bit_idx_i (bit_idx),
        .left_o    (o_rx_left_chan),
        .right_o   (o_rx_right_chan)
    );

    assign o_i2s_bclk = bclk;
    assign o_i2s_ws   = ws;
    assign o_i2s_sd   = sd;

endmodule

// File: tb/tb_i2s_top.sv
// Directed bench for i2s_top: reset timing, loopback data, sample point, mid-frame reset,
// minimum divider, plus an independent Philips-format bus decoder.

module tb_i2s_top;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  p = '0;
    logic [W-1:0]  l = '0;
    logic [W-1:0]  r = '0;
    logic [W-1:0]  rl, rr;
    logic          bclk, ws, sd;

    int errs = 0;
    int checks = 0;

    i2s_top #(.AUDIO_DW(W)) dut (
        .i_tx_sclk       (clk),
        .i_rst_n         (rst_n),
        .i_tx_prescaler  (p),
        .i_tx_left_chan  (l),
        .i_tx_right_chan (r),
        .o_rx_left_chan  (rl),
        .o_rx_right_chan (rr),
        .o_i2s_bclk      (bclk),
        .o_i2s_ws        (ws),
        .o_i2s_sd        (sd)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus decoder: a WS change seen at a rise marks the LSB of the previous slot.
    int          cyc = 0;
    logic        m_pb = 1'b0, m_psd = 1'b0, m_pws = 1'b1, m_rws = 1'b1, m_armed = 1'b0;
    logic [W-1:0] m_acc = '0, dec_l = '0, dec_r = '0;
    int          m_bits = 0, sd_unstable = 0, slot_bad = 0, ws_fall_cyc = -1, ws_period = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            m_armed = 1'b0;
            m_rws = 1'b1;
            m_acc = '0;
            m_bits = 0;
            ws_fall_cyc = -1;
        end else begin
            if (bclk && !m_pb) begin
                if (sd !== m_psd) sd_unstable++;
                if (ws !== m_rws) begin
                    if (m_armed) begin
                        if (m_bits != W - 1) slot_bad++;
                        if (m_rws) dec_r = {m_acc[W-2:0], sd};
                        else       dec_l = {m_acc[W-2:0], sd};
                    end
                    m_armed = 1'b1;
                    m_bits = 0;
                    m_acc = '0;
                    m_rws = ws;
                end else begin
                    m_acc = {m_acc[W-2:0], sd};
                    m_bits++;
                end
            end
            if (m_pws && !ws) begin
                if (ws_fall_cyc >= 0) ws_period = cyc - ws_fall_cyc;
                ws_fall_cyc = cyc;
            end
        end
        m_pb = bclk;
        m_psd = sd;
        m_pws = ws;
    end

    task automatic wait_ws_fall();
        logic pw;
        pw = ws;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (pw && !ws) return;
            pw = ws;
        end
        check_eq("ws_fall_timeout", 1, 0);
    endtask

    task automatic release_measure(output int rise_k, output int fall_k);
        rise_k = 0;
        fall_k = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (rise_k == 0 && bclk) begin
                rise_k = k;
            end else if (rise_k != 0 && !bclk) begin
                fall_k = k;
                break;
            end
        end
    endtask

    initial begin
        int rk, fk, bad;
        logic pb;

        // Reset state and first bclk edges with P=23
        p = 16'd23; l = 16'hA5A5; r = 16'h5A5A;
        repeat (5) @(negedge clk);
        check_eq("rst_left", rl, 16'h0000);
        check_eq("rst_right", rr, 16'h0000);
        check_eq("rst_bclk", bclk, 1'b0);
        check_eq("rst_ws", ws, 1'b1);
        check_eq("rst_sd", sd, 1'b0);
        release_measure(rk, fk);
        check_eq("first_rise", rk, 24);
        check_eq("first_fall", fk, 48);
        check_eq("ws_after_first_fall", ws, 1'b0);

        // Loopback after two frames
        repeat (3072 - 48) @(posedge clk);
        #1;
        check_eq("loop_left", rl, 16'hA5A5);
        check_eq("loop_right", rr, 16'h5A5A);
        check_eq("bus_left", dec_l, 16'hA5A5);
        check_eq("bus_right", dec_r, 16'h5A5A);
        check_eq("ws_period_p23", ws_period, 1536);
        check_eq("sd_stable_p23", sd_unstable, 0);
        check_eq("slot_len_p23", slot_bad, 0);

        // Sample point: change left one clock after the n=1 fall
        l = 16'h1234;
        wait_ws_fall();
        repeat (48) @(posedge clk);
        #1;
        l = 16'hFFFF;
        repeat (743) @(posedge clk);
        #1;
        check_eq("sp_left_before", rl, 16'hA5A5);
        @(posedge clk);
        #1;
        check_eq("sp_left_cur", rl, 16'h1234);
        repeat (1536) @(posedge clk);
        #1;
        check_eq("sp_left_next", rl, 16'hFFFF);
        check_eq("sp_right", rr, 16'h5A5A);

        // Mid-frame reset during n=10
        wait_ws_fall();
        repeat (490) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_left", rl, 16'h0000);
        check_eq("mrst_right", rr, 16'h0000);
        check_eq("mrst_bclk", bclk, 1'b0);
        check_eq("mrst_ws", ws, 1'b1);
        check_eq("mrst_sd", sd, 1'b0);
        l = 16'h3C96; r = 16'hC369;
        repeat (3) @(negedge clk);
        release_measure(rk, fk);
        check_eq("mrst_first_rise", rk, 24);
        check_eq("mrst_first_fall", fk, 48);
        repeat (840 - 48 - 1) @(posedge clk);
        #1;
        check_eq("mrst_left_early", rl, 16'h0000);
        @(posedge clk);
        #1;
        check_eq("mrst_left_on_time", rl, 16'h3C96);
        repeat (1608 - 840 - 1) @(posedge clk);
        #1;
        check_eq("mrst_right_early", rr, 16'h0000);
        @(posedge clk);
        #1;
        check_eq("mrst_right_on_time", rr, 16'hC369);
        repeat (2) @(posedge clk);
        #1;
        check_eq("mrst_bus_left", dec_l, 16'h3C96);
        check_eq("mrst_bus_right", dec_r, 16'hC369);

        // Minimum divider P=0
        @(negedge clk);
        rst_n = 1'b0;
        p = 16'd0; l = 16'h8001; r = 16'h7FFE;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        pb = bclk;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bclk === pb) bad++;
            pb = bclk;
        end
        check_eq("p0_bclk_toggle", bad, 0);
        check_eq("p0_left", rl, 16'h8001);
        repeat (26) @(posedge clk);
        #1;
        check_eq("p0_right_early", rr, 16'h0000);
        @(posedge clk);
        #1;
        check_eq("p0_right", rr, 16'h7FFE);
        repeat (200) @(posedge clk);
        #1;
        check_eq("ws_period_p0", ws_period, 64);
        check_eq("p0_bus_left", dec_l, 16'h8001);
        check_eq("p0_bus_right", dec_r, 16'h7FFE);
        check_eq("sd_stable_all", sd_unstable, 0);
        check_eq("slot_len_all", slot_bad, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
